// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix chip parameters, sequencer states and address helper
package matrix_pkg;

  localparam int DATA_W  = 4;
  localparam int MAX_DIM = 4;
  localparam int DIM_W   = 3;
  localparam int ADDR_W  = 4;
  localparam int ACC_W   = 2*DATA_W + $clog2(MAX_DIM) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE,
    S_ERR
  } seq_state_t;

  // Row-major element address with a fixed MAX_DIM stride, shared with loader and storage
  function automatic logic [ADDR_W-1:0] idx(input logic [DIM_W-1:0] row,
                                            input logic [DIM_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(MAX_DIM) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - registered unsigned multiply-accumulate for one C element
module matmul_mac
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(a) * ACC_W'(b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequences C = A x B: dim check, i/j/k walk, paired reads, result writes
module matmul_sequencer
  import matrix_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  r1,
  input  logic [DIM_W-1:0]  c1,
  input  logic [DIM_W-1:0]  r2,
  input  logic [DIM_W-1:0]  c2,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] ZERO  = '0;

  seq_state_t        state_q;
  logic [DIM_W-1:0]  r1_q, c1_q, r2_q, c2_q;
  logic [DIM_W-1:0]  i_q, j_q, k_q;
  logic              rd_en_q, rd_prev_q, res_we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q, res_addr_q;
  logic [ACC_W-1:0]  acc;
  logic              dims_bad;
  logic              mac_clr;

  assign dims_bad = (r1_q == ZERO) || (c1_q == ZERO) || (r2_q == ZERO) || (c2_q == ZERO) ||
                    (r1_q > MAX_D) || (c1_q > MAX_D) || (r2_q > MAX_D) || (c2_q > MAX_D) ||
                    (c1_q != r2_q);

  // Accumulator starts clean for the first element and after every write-out
  assign mac_clr = (state_q == S_CHECK) || (state_q == S_WRITE);

  matmul_mac u_mac (
    .clk (CLK),
    .rst (RST),
    .clr (mac_clr),
    .en  (rd_prev_q),
    .a   (a_data),
    .b   (b_data),
    .acc (acc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      r1_q       <= '0;
      c1_q       <= '0;
      r2_q       <= '0;
      c2_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_prev_q  <= 1'b0;
      res_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      res_addr_q <= '0;
    end else begin
      // Strobes and addresses are one-cycle unless the next state re-asserts them
      rd_en_q    <= 1'b0;
      res_we_q   <= 1'b0;
      done_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      res_addr_q <= '0;
      rd_prev_q  <= rd_en_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            r1_q    <= r1;
            c1_q    <= c1;
            r2_q    <= r2;
            c2_q    <= c2;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dims_bad) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_ERR;
          end else begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            rd_en_q <= 1'b1;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == c1_q - ONE) begin
            state_q <= S_DRAIN;
          end else begin
            k_q      <= k_q + ONE;
            rd_en_q  <= 1'b1;
            a_addr_q <= idx(i_q, k_q + ONE);
            b_addr_q <= idx(k_q + ONE, j_q);
          end
        end
        S_DRAIN: begin
          res_we_q   <= 1'b1;
          res_addr_q <= idx(i_q, j_q);
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          k_q <= '0;
          if (j_q < c2_q - ONE) begin
            j_q      <= j_q + ONE;
            rd_en_q  <= 1'b1;
            a_addr_q <= idx(i_q, ZERO);
            b_addr_q <= idx(ZERO, j_q + ONE);
            state_q  <= S_MAC;
          end else if (i_q < r1_q - ONE) begin
            i_q      <= i_q + ONE;
            j_q      <= '0;
            rd_en_q  <= 1'b1;
            a_addr_q <= idx(i_q + ONE, ZERO);
            state_q  <= S_MAC;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en    = rd_en_q;
  assign a_addr   = a_addr_q;
  assign b_addr   = b_addr_q;
  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;
  assign res_data = res_we_q ? acc : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer
module tb_matmul_sequencer;
  import matrix_pkg::*;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  r1 = '0, c1 = '0, r2 = '0, c2 = '0;
  logic              rd_en, res_we, busy, done, err;
  logic [ADDR_W-1:0] a_addr, b_addr, res_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [ACC_W-1:0]  res_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int mon_len = 0;
  bit mon_on = 1'b0;
  int mc;

  logic [DATA_W-1:0] mem_a [16];
  logic [DATA_W-1:0] mem_b [16];

  // Expected timeline, indexed by cycle number relative to the accepting edge
  bit e_busy [256];
  bit e_done [256];
  bit e_err  [256];
  bit e_rd   [256];
  bit e_we   [256];
  int e_a    [256];
  int e_b    [256];
  int e_ra   [256];
  int e_rv   [256];
  int exp_c  [16];
  int exp_done;

  int wr_n = 0;
  int wr_addr [256];
  int wr_val  [256];

  matmul_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .r1       (r1),
    .c1       (c1),
    .r2       (r2),
    .c2       (c2),
    .rd_en    (rd_en),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .res_we   (res_we),
    .res_addr (res_addr),
    .res_data (res_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Storage model: one-cycle read latency on both stores
  always @(posedge CLK) begin
    if (rd_en) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
    end
  end

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, c, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, 0, 32'(rd_en), 0);
    chk({nm, "_res_we"}, 0, 32'(res_we), 0);
    chk({nm, "_busy"}, 0, 32'(busy), 0);
    chk({nm, "_done"}, 0, 32'(done), 0);
    chk({nm, "_err"}, 0, 32'(err), 0);
    chk({nm, "_a_addr"}, 0, 32'(a_addr), 0);
    chk({nm, "_b_addr"}, 0, 32'(b_addr), 0);
    chk({nm, "_res_addr"}, 0, 32'(res_addr), 0);
    chk({nm, "_res_data"}, 0, 32'(res_data), 0);
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      mc = cyc - base + 1;
      if (mc >= 1 && mc <= mon_len) begin
        chk("busy", mc, 32'(busy), 32'(e_busy[mc]));
        chk("done", mc, 32'(done), 32'(e_done[mc]));
        chk("err", mc, 32'(err), 32'(e_err[mc]));
        chk("rd_en", mc, 32'(rd_en), 32'(e_rd[mc]));
        chk("res_we", mc, 32'(res_we), 32'(e_we[mc]));
        if (e_rd[mc]) begin
          chk("a_addr", mc, 32'(a_addr), e_a[mc]);
          chk("b_addr", mc, 32'(b_addr), e_b[mc]);
        end
        if (e_we[mc]) begin
          chk("res_addr", mc, 32'(res_addr), e_ra[mc]);
          chk("res_data", mc, 32'(res_data), e_rv[mc]);
        end
        if (res_we && wr_n < 256) begin
          wr_addr[wr_n] = int'(res_addr);
          wr_val[wr_n]  = int'(res_data);
          wr_n++;
        end
      end
    end
  end

  task automatic model(input int rr1, input int cc1, input int rr2, input int cc2, input int tail);
    bit bad;
    int per, t0, sum;
    for (int c = 0; c < 256; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_rd[c] = 0; e_we[c] = 0;
      e_a[c] = 0; e_b[c] = 0; e_ra[c] = 0; e_rv[c] = 0;
    end
    for (int a = 0; a < 16; a++) exp_c[a] = -1;
    bad = (rr1 == 0) || (cc1 == 0) || (rr2 == 0) || (cc2 == 0) ||
          (rr1 > MAX_DIM) || (cc1 > MAX_DIM) || (rr2 > MAX_DIM) || (cc2 > MAX_DIM) ||
          (cc1 != rr2);
    if (bad) begin
      exp_done = 2;
      for (int c = 2; c <= exp_done + tail; c++) e_err[c] = 1;
    end else begin
      per = cc1 + 2;
      for (int i = 0; i < rr1; i++) begin
        for (int j = 0; j < cc2; j++) begin
          t0 = 2 + (i * cc2 + j) * per;
          sum = 0;
          for (int k = 0; k < cc1; k++) begin
            e_rd[t0 + k] = 1;
            e_a[t0 + k] = i * MAX_DIM + k;
            e_b[t0 + k] = k * MAX_DIM + j;
            sum += int'(mem_a[i * MAX_DIM + k]) * int'(mem_b[k * MAX_DIM + j]);
          end
          e_we[t0 + cc1 + 1] = 1;
          e_ra[t0 + cc1 + 1] = i * MAX_DIM + j;
          e_rv[t0 + cc1 + 1] = sum;
          exp_c[i * MAX_DIM + j] = sum;
        end
      end
      exp_done = 2 + rr1 * cc2 * per;
    end
    for (int c = 1; c <= exp_done; c++) e_busy[c] = 1;
    e_done[exp_done] = 1;
    mon_len = exp_done + tail;
  endtask

  // Called one time unit after a rising edge; returns one time unit into cycle mon_len+1
  task automatic run(input int rr1, input int cc1, input int rr2, input int cc2,
                     input int tail, input int inj1, input int inj2);
    model(rr1, cc1, rr2, cc2, tail);
    r1 = DIM_W'(rr1); c1 = DIM_W'(cc1); r2 = DIM_W'(rr2); c2 = DIM_W'(cc2);
    start = 1'b1;
    @(posedge CLK); #1;
    base = cyc;
    start = 1'b0;
    mon_on = 1'b1;
    for (int n = 1; n <= mon_len; n++) begin
      if (n == inj1 || n == inj2) begin
        start = 1'b1;
        r1 = 3'd1; c1 = 3'd4; r2 = 3'd4; c2 = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    mon_on = 1'b0;
  endtask

  task automatic load_t2();
    for (int a = 0; a < 16; a++) begin
      mem_a[a] = '0;
      mem_b[a] = '0;
    end
    mem_a[0] = 4'd2; mem_a[1] = 4'd3; mem_a[4] = 4'd2; mem_a[5] = 4'd1;
    mem_b[0] = 4'd0; mem_b[1] = 4'd9; mem_b[4] = 4'd7; mem_b[5] = 4'd4;
  endtask

  task automatic chk_t2_writes(input string nm, input int w0);
    chk({nm, "_count"}, 0, wr_n - w0, 4);
    chk({nm, "_w0"}, 0, wr_val[w0], 21);
    chk({nm, "_w1"}, 0, wr_val[w0 + 1], 30);
    chk({nm, "_w2"}, 0, wr_val[w0 + 2], 7);
    chk({nm, "_w3"}, 0, wr_val[w0 + 3], 22);
    chk({nm, "_a0"}, 0, wr_addr[w0], 0);
    chk({nm, "_a1"}, 0, wr_addr[w0 + 1], 1);
    chk({nm, "_a2"}, 0, wr_addr[w0 + 2], 4);
    chk({nm, "_a3"}, 0, wr_addr[w0 + 3], 5);
  endtask

  initial begin
    int w0;
    load_t2();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST = 1'b0;

    // 2x2 reference product
    w0 = wr_n;
    run(2, 2, 2, 2, 0, 0, 0);
    chk("t2_model_done_cycle", 0, exp_done, 18);
    chk("t2_model_c00", 0, exp_c[0], 21);
    chk("t2_model_c11", 0, exp_c[5], 22);
    chk_t2_writes("t2", w0);

    // Same run with stray starts and changing dims while busy
    w0 = wr_n;
    run(2, 2, 2, 2, 0, 3, 10);
    chk_t2_writes("t6", w0);

    // 1x1, started the cycle right after the previous done
    mem_a[0] = 4'd15; mem_b[0] = 4'd15;
    w0 = wr_n;
    run(1, 1, 1, 1, 0, 0, 0);
    chk("t4_model_done_cycle", 0, exp_done, 5);
    chk("t4_count", 0, wr_n - w0, 1);
    chk("t4_val", 0, wr_val[w0], 225);
    chk("t4_addr", 0, wr_addr[w0], 0);

    // Inner dimension mismatch, err held over idle tail
    w0 = wr_n;
    run(2, 3, 2, 1, 6, 0, 0);
    chk("t3_model_done_cycle", 0, exp_done, 2);
    chk("t3_count", 0, wr_n - w0, 0);

    // Dimension above MAX_DIM
    run(5, 2, 2, 2, 2, 0, 0);

    // Full 4x4 of max values
    for (int a = 0; a < 16; a++) begin
      mem_a[a] = 4'd15;
      mem_b[a] = 4'd15;
    end
    w0 = wr_n;
    run(4, 4, 4, 4, 0, 0, 0);
    chk("t5_model_done_cycle", 0, exp_done, 98);
    chk("t5_count", 0, wr_n - w0, 16);
    for (int n = 0; n < 16; n++) begin
      chk("t5_val", n, wr_val[w0 + n], 900);
      chk("t5_addr", n, wr_addr[w0 + n], n);
    end

    // Reset held three cycles in the middle of a 2x2 MAC
    load_t2();
    r1 = 3'd2; c1 = 3'd2; r2 = 3'd2; c2 = 3'd2;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t1_in_mac", 0, 32'(rd_en), 1);
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      chk_zero("t1_rst");
    end
    RST = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      chk("t1_after_res_we", 0, 32'(res_we), 0);
      chk("t1_after_rd_en", 0, 32'(rd_en), 0);
      chk("t1_after_busy", 0, 32'(busy), 0);
      chk("t1_after_done", 0, 32'(done), 0);
    end

    // Recovery after reset
    w0 = wr_n;
    run(2, 2, 2, 2, 0, 0, 0);
    chk_t2_writes("t1_recover", w0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
